thiele_engine_arbiter: RTL and testbench

//   Shares one external engine port (logic or Python co-processor) among N_CH

---
 rtl/thiele_engine_arbiter.sv | 146 ++++++++++++++
 tb/tb_thiele_engine_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/thiele_engine_arbiter.sv
//------------------------------------------------------------------------------
// thiele_engine_arbiter : round-robin share of one engine port among N_CH
// requesters, with bounded-wait timeout and saturating statistics. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module thiele_engine_arbiter #(
  parameter int N_CH    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           ch_req,
  input  logic [N_CH*ADDR_W-1:0]    ch_addr,
  output logic [N_CH-1:0]           ch_ack,
  output logic [DATA_W-1:0]         ch_data,
  output logic [N_CH-1:0]           ch_err,
  output logic                      eng_req,
  output logic [ADDR_W-1:0]         eng_addr,
  input  logic                      eng_ack,
  input  logic [DATA_W-1:0]         eng_data,
  output logic                      busy,
  output logic [$clog2(N_CH)-1:0]   grant_id,
  output logic [CNT_W-1:0]          served_cnt,
  output logic [CNT_W-1:0]          timeout_cnt
);

  localparam int GW = $clog2(N_CH);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state, w_state_nx;
  logic [GW-1:0]     r_last, w_last_nx;
  logic [WW-1:0]     r_wait, w_wait_nx;
  logic [GW-1:0]     w_pick;
  logic              w_found;

  logic [N_CH-1:0]   w_ack_nx, w_err_nx;
  logic [DATA_W-1:0] w_data_nx;
  logic [ADDR_W-1:0] w_addr_nx;
  logic [GW-1:0]     w_grant_nx;
  logic [CNT_W-1:0]  w_served_nx, w_timeout_nx;

  // First requesting channel after the last one served, wrapping around.
  always_comb begin : p_pick
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = r_last;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(r_last) + k) % N_CH;
      if (!w_found && ch_req[idx]) begin
        w_found = 1'b1;
        w_pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_last_nx    = r_last;
    w_wait_nx    = r_wait;
    w_ack_nx     = '0;
    w_err_nx     = '0;
    w_data_nx    = '0;
    w_addr_nx    = eng_addr;
    w_grant_nx   = grant_id;
    w_served_nx  = served_cnt;
    w_timeout_nx = timeout_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nx = S_REQ;
          w_addr_nx  = ch_addr[int'(w_pick)*ADDR_W +: ADDR_W];
          w_grant_nx = w_pick;
          w_last_nx  = w_pick;
          w_wait_nx  = '0;
        end
      end
      S_REQ: begin
        // An ack in the last timeout cycle still wins over the timeout.
        if (eng_ack) begin
          w_state_nx         = S_RESP;
          w_ack_nx[grant_id] = 1'b1;
          w_data_nx          = eng_data;
        end else if ((TIMEOUT != 0) && (r_wait == WW'(TIMEOUT - 1))) begin
          w_state_nx         = S_RESP;
          w_ack_nx[grant_id] = 1'b1;
          w_err_nx[grant_id] = 1'b1;
        end else begin
          w_wait_nx = r_wait + 1'b1;
        end
      end
      S_RESP: begin
        w_state_nx = S_IDLE;
        if (|ch_err) begin
          if (timeout_cnt != '1) w_timeout_nx = timeout_cnt + 1'b1;
        end else begin
          if (served_cnt != '1) w_served_nx = served_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= GW'(N_CH - 1);
      r_wait      <= '0;
      ch_ack      <= '0;
      ch_err      <= '0;
      ch_data     <= '0;
      eng_req     <= 1'b0;
      eng_addr    <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      served_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_last      <= w_last_nx;
      r_wait      <= w_wait_nx;
      ch_ack      <= w_ack_nx;
      ch_err      <= w_err_nx;
      ch_data     <= w_data_nx;
      eng_req     <= (w_state_nx == S_REQ);
      eng_addr    <= w_addr_nx;
      busy        <= (w_state_nx != S_IDLE);
      grant_id    <= w_grant_nx;
      served_cnt  <= w_served_nx;
      timeout_cnt <= w_timeout_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_thiele_engine_arbiter.sv
//------------------------------------------------------------------------------
// tb_thiele_engine_arbiter : directed and randomized checks of the engine
// arbiter against a transaction-level reference model. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_thiele_engine_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      ch_req;
  logic [N*AW-1:0]   ch_addr;
  logic [N-1:0]      ch_ack;
  logic [DW-1:0]     ch_data;
  logic [N-1:0]      ch_err;
  logic              eng_req;
  logic [AW-1:0]     eng_addr;
  logic              eng_ack;
  logic [DW-1:0]     eng_data;
  logic              busy;
  logic [1:0]        grant_id;
  logic [CW-1:0]     served_cnt;
  logic [CW-1:0]     timeout_cnt;

  thiele_engine_arbiter #(
    .N_CH(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_addr(ch_addr),
    .ch_ack(ch_ack), .ch_data(ch_data), .ch_err(ch_err),
    .eng_req(eng_req), .eng_addr(eng_addr), .eng_ack(eng_ack),
    .eng_data(eng_data), .busy(busy), .grant_id(grant_id),
    .served_cnt(served_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: who was served last and how many of each outcome.
  int m_last;
  int m_served;
  int m_timeout;
  int grant_log[$];
  logic [AW-1:0] addr_tbl [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addr();
    for (int i = 0; i < N; i++) ch_addr[i*AW +: AW] = addr_tbl[i];
  endtask

  task automatic model_reset();
    m_last    = N - 1;
    m_served  = 0;
    m_timeout = 0;
  endtask

  // One full transaction, starting and ending at an IDLE cycle.
  // delay = number of REQ cycles before the ack cycle; negative = never ack.
  task automatic do_txn(input logic [N-1:0] req, input int delay,
                        input logic [DW-1:0] data, input logic drop);
    int  g;
    int  cyc;
    int  exp_cyc;
    bit  ok;
    bit  done;
    g = -1;
    for (int k = 1; k <= N; k++)
      if (g < 0 && req[(m_last + k) % N]) g = (m_last + k) % N;
    ok      = (delay >= 0) && (delay < TO);
    exp_cyc = ok ? delay + 1 : TO;

    drive_addr();
    ch_req  = req;
    eng_ack = 1'($urandom_range(0, 1));
    tick();
    chk("eng_req_rise", {63'd0, eng_req}, 64'd1);
    chk("eng_addr", {32'd0, eng_addr}, {32'd0, addr_tbl[g]});
    chk("grant_id", {62'd0, grant_id}, 64'(g));
    grant_log.push_back(int'(grant_id));

    cyc  = 0;
    done = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (!eng_req) begin
        done = 1'b1;
        break;
      end
      cyc++;
      chk("busy_req", {63'd0, busy}, 64'd1);
      if (drop) ch_req = '0;
      eng_ack  = (delay == cyc - 1);
      eng_data = data;
      tick();
    end
    chk("req_bounded", {63'd0, done}, 64'd1);
    chk("eng_req_cycles", 64'(cyc), 64'(exp_cyc));

    chk("resp_ack", {60'd0, ch_ack}, 64'(1) << g);
    chk("resp_err", {60'd0, ch_err}, ok ? 64'd0 : (64'(1) << g));
    chk("resp_data", {32'd0, ch_data}, ok ? {32'd0, data} : 64'd0);
    chk("busy_resp", {63'd0, busy}, 64'd1);
    eng_ack = 1'($urandom_range(0, 1));
    ch_req  = '0;
    tick();
    eng_ack = 1'b0;

    m_last = g;
    if (ok) m_served  = (m_served  + 1 > 2**CW - 1) ? 2**CW - 1 : m_served + 1;
    else    m_timeout = (m_timeout + 1 > 2**CW - 1) ? 2**CW - 1 : m_timeout + 1;
    chk("idle_ack", {60'd0, ch_ack}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("served_cnt", {60'd0, served_cnt}, 64'(m_served));
    chk("timeout_cnt", {60'd0, timeout_cnt}, 64'(m_timeout));
  endtask

  initial begin
    bit stray;
    rst      = 1'b1;
    ch_req   = '0;
    ch_addr  = '0;
    eng_ack  = 1'b0;
    eng_data = '0;
    for (int i = 0; i < N; i++) addr_tbl[i] = 32'h1000 * (i + 1);
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_eng_req", {63'd0, eng_req}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ack", {60'd0, ch_ack}, 64'd0);
    chk("rst_err", {60'd0, ch_err}, 64'd0);
    chk("rst_data", {32'd0, ch_data}, 64'd0);
    chk("rst_addr", {32'd0, eng_addr}, 64'd0);
    chk("rst_grant", {62'd0, grant_id}, 64'd0);
    chk("rst_served", {60'd0, served_cnt}, 64'd0);
    chk("rst_timeout", {60'd0, timeout_cnt}, 64'd0);

    // Single request on channel 1.
    addr_tbl[1] = 32'h100;
    do_txn(4'b0010, 3, 32'hABCD1234, 1'b0);

    // All four requesting with immediate ack: strict rotation from channel 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    grant_log.delete();
    do_txn(4'b1111, 0, 32'h11111111, 1'b0);
    do_txn(4'b1110, 0, 32'h22222222, 1'b0);
    do_txn(4'b1100, 0, 32'h33333333, 1'b0);
    do_txn(4'b1000, 0, 32'h44444444, 1'b0);
    chk("rr_order", {32'd0, grant_log[0][7:0], grant_log[1][7:0],
                     grant_log[2][7:0], grant_log[3][7:0]}, 64'h00010203);

    // Channels 0 and 2 both hammering: they alternate.
    grant_log.delete();
    for (int i = 0; i < 4; i++) do_txn(4'b0101, 1, $urandom, 1'b0);
    chk("no_starve", {32'd0, grant_log[0][7:0], grant_log[1][7:0],
                      grant_log[2][7:0], grant_log[3][7:0]}, 64'h00020002);

    // Timeout, then ack in the final timeout cycle, with requester drop.
    do_txn(4'b0100, -1, 32'hDEADBEEF, 1'b0);
    do_txn(4'b0100, TO - 1, 32'hCAFEF00D, 1'b1);

    // Reset in the middle of a request.
    ch_req = 4'b0001;
    tick();
    chk("pre_rst_req", {63'd0, eng_req}, 64'd1);
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    ch_req = '0;
    model_reset();
    chk("mid_rst_eng_req", {63'd0, eng_req}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_served", {60'd0, served_cnt}, 64'd0);
    chk("mid_rst_timeout", {60'd0, timeout_cnt}, 64'd0);
    stray = 1'b0;
    eng_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (ch_ack != '0 || eng_req) stray = 1'b1;
      tick();
    end
    eng_ack = 1'b0;
    chk("mid_rst_no_ack", {63'd0, stray}, 64'd0);

    // Twenty successes: served counter saturates.
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < N; j++) addr_tbl[j] = $urandom;
      do_txn(4'($urandom_range(1, 15)), $urandom_range(0, TO - 1), $urandom, 1'b0);
    end
    chk("served_sat", {60'd0, served_cnt}, 64'd15);

    // Random mix of successes, timeouts, late acks and requester drops.
    for (int i = 0; i < 25; i++) begin
      for (int j = 0; j < N; j++) addr_tbl[j] = $urandom;
      do_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, TO + 1)) - 1,
             $urandom, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
